// File: rtl/line_buffer.sv
// Raster-to-column converter: buffers BLOCK_HEIGHT-1 previous lines in circular
// line memories and emits one BLOCK_HEIGHT-tall column per accepted pixel.
module line_buffer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned BLOCK_HEIGHT = 3,
    parameter int unsigned IMAGE_WIDTH  = 640,
    parameter int unsigned IMAGE_HEIGHT = 480,
    parameter int unsigned OUTPUT_WIDTH = DATA_WIDTH * BLOCK_HEIGHT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   in_pixel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUTPUT_WIDTH-1:0] out_pixels,
    output logic [BLOCK_HEIGHT-1:0] out_valid,
    input  logic [BLOCK_HEIGHT-1:0] out_ready
);

    localparam int unsigned CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int unsigned RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    logic [DATA_WIDTH-1:0]   line_mem [BLOCK_HEIGHT-1][IMAGE_WIDTH];
    logic [CW-1:0]           col_cnt;
    logic [RW-1:0]           row_cnt;
    logic [OUTPUT_WIDTH-1:0] column;
    logic                    accept;
    logic                    out_xfer;
    logic                    primed;

    assign out_xfer = out_valid[0] && (&out_ready);
    assign in_ready = !out_valid[0] || (&out_ready);
    assign accept   = in_valid && in_ready;
    assign primed   = row_cnt >= RW'(BLOCK_HEIGHT - 1);

    // Slice 0 is the oldest line (deepest memory), top slice is the live pixel.
    always_comb begin
        column = '0;
        for (int unsigned i = 0; i < BLOCK_HEIGHT - 1; i++)
            column[i*DATA_WIDTH +: DATA_WIDTH] = line_mem[BLOCK_HEIGHT-2-i][col_cnt];
        column[(BLOCK_HEIGHT-1)*DATA_WIDTH +: DATA_WIDTH] = in_pixel;
    end

    // Line memories are not reset; each line shifts one slot deeper on accept.
    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            line_mem[0][col_cnt] <= in_pixel;
            for (int unsigned j = 1; j < BLOCK_HEIGHT - 1; j++)
                line_mem[j][col_cnt] <= line_mem[j-1][col_cnt];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (accept) begin
            if (col_cnt == CW'(IMAGE_WIDTH - 1)) begin
                col_cnt <= '0;
                row_cnt <= (row_cnt == RW'(IMAGE_HEIGHT - 1)) ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    // Accept while priming clears the register: any held column drains this same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= '0;
            out_pixels <= '0;
        end else if (accept) begin
            if (primed) begin
                out_pixels <= column;
                out_valid  <= '1;
            end else begin
                out_valid  <= '0;
            end
        end else if (out_xfer) begin
            out_valid <= '0;
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Directed, table-driven bench for line_buffer on a 4x4 image with 3-row columns.
module tb_line_buffer;

    localparam int unsigned DW = 8;
    localparam int unsigned BH = 3;
    localparam int unsigned IW = 4;
    localparam int unsigned IH = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   in_pixel;
    logic            in_valid;
    logic            in_ready;
    logic [DW*BH-1:0] out_pixels;
    logic [BH-1:0]   out_valid;
    logic [BH-1:0]   out_ready;

    int tests = 0;
    int fails = 0;
    int cols  = 0;

    line_buffer #(
        .DATA_WIDTH  (DW),
        .BLOCK_HEIGHT(BH),
        .IMAGE_WIDTH (IW),
        .IMAGE_HEIGHT(IH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_pixels(out_pixels),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        r;
        bit        iv;
        bit [7:0]  px;
        bit [2:0]  ordy;
        bit        chk_ir;
        bit        exp_ir;
        bit        exp_ov;
        bit [23:0] exp_px;
        string     name;
    } vec_t;

    vec_t vecs[$];

    function automatic bit [23:0] col_of(input bit [7:0] px);
        bit [7:0] a, b;
        a = px - 8'h10;
        b = px - 8'h20;
        return {px, a, b};
    endfunction

    function automatic vec_t mk(input bit r, input bit iv, input bit [7:0] px,
                                input bit [2:0] ordy, input bit chk_ir, input bit exp_ir,
                                input bit exp_ov, input bit [23:0] exp_px, input string name);
        vec_t v;
        v.r = r; v.iv = iv; v.px = px; v.ordy = ordy; v.chk_ir = chk_ir;
        v.exp_ir = exp_ir; v.exp_ov = exp_ov; v.exp_px = exp_px; v.name = name;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rst       = v.r;
        in_valid  = v.iv;
        in_pixel  = v.px;
        out_ready = v.ordy;
        #1;
        if (v.chk_ir) check({v.name, " in_ready"}, 32'(in_ready), 32'(v.exp_ir));
        @(posedge clk);
        #1;
        check({v.name, " out_valid"}, 32'(out_valid), v.exp_ov ? 32'h7 : 32'h0);
        if (v.exp_ov) check({v.name, " out_pixels"}, 32'(out_pixels), 32'(v.exp_px));
        if (v.r)      check({v.name, " out_pixels_rst"}, 32'(out_pixels), 32'h0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pixel = '0; out_ready = '1;

        // Reset
        vecs.push_back(mk(1, 0, 8'h00, 3'b111, 0, 0, 0, 24'h0, "reset0"));
        vecs.push_back(mk(1, 0, 8'h00, 3'b111, 1, 1, 0, 24'h0, "reset1"));
        // Frame 1 at full throughput
        for (int r = 0; r < IH; r++)
            for (int c = 0; c < IW; c++) begin
                bit [7:0] p;
                p = 8'(r * 16 + c);
                vecs.push_back(mk(0, 1, p, 3'b111, 1, 1, r >= 2, col_of(p), "frame1"));
            end
        // Frame 2 back-to-back: re-prime, then first column
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IW; c++)
                vecs.push_back(mk(0, 1, 8'(r * 16 + c), 3'b111, 1, 1, 0, 24'h0, "frame2_prime"));
        vecs.push_back(mk(0, 1, 8'h20, 3'b111, 1, 1, 1, 24'h201000, "frame2_first"));
        // Partial ready stalls everything
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(0, 1, 8'h21, 3'b101, 1, 0, 1, 24'h201000, "stall"));
        vecs.push_back(mk(0, 1, 8'h21, 3'b111, 1, 1, 1, 24'h211101, "resume"));
        vecs.push_back(mk(0, 1, 8'h22, 3'b111, 1, 1, 1, 24'h221202, "resume2"));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
            if (i >= 2 && i < 18 && out_valid[0]) cols++;
        end
        check("frame1_column_count", 32'(cols), 32'd8);

        // Mid-frame reset during row 2 with a column held; the pixel offered is dropped
        step(mk(1, 1, 8'h23, 3'b111, 1, 1, 0, 24'h0, "midreset"));
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IW; c++)
                step(mk(0, 1, 8'(r * 16 + c), 3'b111, 1, 1, 0, 24'h0, "post_reset_prime"));
        step(mk(0, 1, 8'h20, 3'b111, 1, 1, 1, 24'h201000, "post_reset_first"));
        // Idle drain: held column transfers, register empties
        step(mk(0, 0, 8'h00, 3'b111, 1, 1, 0, 24'h0, "drain"));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/line_buffer.md
Name: line_buffer

Overview:
- Upstream neighbour of the window shift-register stage; converts a raster pixel stream into vertical columns of BLOCK_HEIGHT pixels.
- Stores BLOCK_HEIGHT-1 previous image lines in circular line memories.
- Emits one column per accepted pixel once enough lines are buffered, using per-row valid/ready vectors that plug straight into the window stage.

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- BLOCK_HEIGHT, 3, window rows; output column height (>=2).
- IMAGE_WIDTH, 640, pixels per line.
- IMAGE_HEIGHT, 480, lines per frame.
- OUTPUT_WIDTH, DATA_WIDTH*BLOCK_HEIGHT, packed column width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_pixel  input  DATA_WIDTH  raster-order pixel.
- in_valid  input  1  in_pixel valid.
- in_ready  output  1  stage accepts in_pixel this cycle.
- out_pixels  output  OUTPUT_WIDTH  column; slice i at [i*DATA_WIDTH +: DATA_WIDTH]; i=0 oldest line (top), i=BLOCK_HEIGHT-1 current line (bottom).
- out_valid  output  BLOCK_HEIGHT  per-row valid; all bits always equal.
- out_ready  input  BLOCK_HEIGHT  per-row ready from downstream.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. It overrides everything, including a transfer in the same cycle.
- Reset values: out_valid=0, out_pixels=0, col_cnt=0, row_cnt=0. in_ready=1 after reset because it is derived from out_valid. Line memory contents are not reset; they are don't-care until overwritten.
- Accept: an input transfer happens when in_valid && in_ready.
- Output transfer: happens when out_valid[0] && (&out_ready). A partial out_ready (not all bits high) is not a transfer: column held, out_valid held.
- in_ready = !out_valid[0] || (&out_ready). Single output register with pass-through when drained; full throughput of 1 pixel/cycle.
- Memory: BLOCK_HEIGHT-1 line memories L[0..BLOCK_HEIGHT-2], IMAGE_WIDTH entries each, indexed by col_cnt, combinational read. L[0] holds the previous line, L[j] holds the line j+1 back.
- On accept at col c:
  - column = {in_pixel, L[0][c], ..., L[BLOCK_HEIGHT-2][c]}, mapped so slice BLOCK_HEIGHT-1 = in_pixel and slice 0 = L[BLOCK_HEIGHT-2][c].
  - Write L[0][c] <= in_pixel and L[j][c] <= L[j-1][c]; all reads use pre-write values.
- Output register load on accept:
  - If row_cnt >= BLOCK_HEIGHT-1: out_pixels <= column, out_valid <= all ones. Latency 1 cycle from accept to out_valid.
  - Else (priming rows): out_valid <= 0 unless... the output register is empty, so no load occurs; the pixel is only written to memory.
- Output register, no accept that cycle: if an output transfer occurs, out_valid <= 0; otherwise hold.
- Counters advance only on accept:
  - col_cnt increments; wraps IMAGE_WIDTH-1 -> 0 and increments row_cnt.
  - row_cnt wraps IMAGE_HEIGHT-1 -> 0 at the last pixel of the frame.
  - The next frame re-primes: its first BLOCK_HEIGHT-1 lines produce no output, and stale memory from the previous frame is never emitted.
- Simultaneous output transfer and accept in the same cycle: the register is replaced by the new column (or cleared if priming). No bubble, no loss.
- Stall: if downstream holds any out_ready bit low with out_valid high, then in_ready=0, and counters, memory and outputs are frozen.
- Output count: exactly (IMAGE_HEIGHT-BLOCK_HEIGHT+1)*IMAGE_WIDTH columns per frame, in raster order.
- Reset mid-frame: counters to 0, out_valid drops next edge, and the next accepted pixel is treated as row 0, col 0.

Test Plan (all with IMAGE_WIDTH=4, IMAGE_HEIGHT=4, BLOCK_HEIGHT=3, DATA_WIDTH=8, pixel = row*16+col):
- Priming: stream rows 0-1 with out_ready=3'b111 -> in_ready stays 1, out_valid stays 3'b000 for all 8 pixels.
- First column: accept pixel 0x20 -> next cycle out_valid=3'b111, out_pixels={0x20,0x10,0x00} (slice 2..0).
- Full-throughput frame: continuous stream of 16 pixels, out_ready=all ones -> exactly 8 columns. The column for pixel 0x33 is {0x33,0x23,0x13}. No cycle has in_ready=0.
- Backpressure: set out_ready=3'b101 while out_valid=1 for 3 cycles -> in_ready=0, out_pixels/out_valid held, counters unchanged. Restoring 3'b111 transfers the held column once and resumes.
- Frame wrap: start a second frame immediately after pixel 0x33 -> 8 priming pixels produce no output, then the first column is {0x20,0x10,0x00} of the new frame, with no stale data emitted.
- Mid-frame reset: assert rst for 1 cycle during row 2 with out_valid=1 -> out_valid=0 next cycle. Then 8 pixels are consumed silently before any output.
